// File: rtl/md_hilo_sched.sv
// rtl/md_hilo_sched.sv - E-stage multiply/divide scheduler and HI/LO owner
// Optional: define MDU_PERF_CNT_EN to add the stall_cnt cycle counter output.
module md_hilo_sched #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_en,
   input  logic [3:0]  hilo_type,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        d_md_use,
   output logic        start,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hilo_out,
   output logic [31:0] hi,
   output logic [31:0] lo
`ifdef MDU_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [3:0] HILO_NONE  = 4'd0;
   localparam logic [3:0] HILO_MULT  = 4'd1;
   localparam logic [3:0] HILO_MULTU = 4'd2;
   localparam logic [3:0] HILO_DIV   = 4'd3;
   localparam logic [3:0] HILO_DIVU  = 4'd4;
   localparam logic [3:0] HILO_MFLO  = 4'd5;
   localparam logic [3:0] HILO_MFHI  = 4'd6;
   localparam logic [3:0] HILO_MTLO  = 4'd7;
   localparam logic [3:0] HILO_MTHI  = 4'd8;

   localparam int CNT_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   shadow_hi;
   logic [31:0]   shadow_lo;
   logic          shadow_wr;

   logic          is_mult;
   logic          is_div;
   logic          is_signed;
   logic [63:0]   ext_a;
   logic [63:0]   ext_b;
   logic [63:0]   prod;
   logic          neg_a;
   logic          neg_b;
   logic [31:0]   mag_a;
   logic [31:0]   mag_b;
   logic [31:0]   dvs;
   logic [31:0]   uq;
   logic [31:0]   ur;
   logic [31:0]   quo;
   logic [31:0]   rem;

   always_comb begin
      is_mult   = (hilo_type == HILO_MULT) || (hilo_type == HILO_MULTU);
      is_div    = (hilo_type == HILO_DIV)  || (hilo_type == HILO_DIVU);
      is_signed = (hilo_type == HILO_MULT) || (hilo_type == HILO_DIV);
   end

   // Sign-extending to 64 bits makes the low half of an unsigned multiply equal the signed product.
   always_comb begin
      ext_a = is_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
      ext_b = is_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
      prod  = ext_a * ext_b;
   end

   // Divide on magnitudes; 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
   always_comb begin
      neg_a = is_signed & src_a[31];
      neg_b = is_signed & src_b[31];
      mag_a = neg_a ? (32'd0 - src_a) : src_a;
      mag_b = neg_b ? (32'd0 - src_b) : src_b;
      dvs   = (src_b == 32'd0) ? 32'd1 : mag_b;
      uq    = mag_a / dvs;
      ur    = mag_a % dvs;
      quo   = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
      rem   = neg_a ? (32'd0 - ur) : ur;
   end

   always_comb begin
      start    = (state == S_IDLE) && req_en && (is_mult || is_div);
      stall_md = d_md_use && (start || busy);
      case (hilo_type)
         HILO_MFHI: hilo_out = hi;
         HILO_MFLO: hilo_out = lo;
         default:   hilo_out = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         shadow_hi <= 32'd0;
         shadow_lo <= 32'd0;
         shadow_wr <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  shadow_hi <= is_mult ? prod[63:32] : rem;
                  shadow_lo <= is_mult ? prod[31:0]  : quo;
                  // A zero divisor still occupies the unit but must leave HI/LO alone.
                  shadow_wr <= is_mult || (src_b != 32'd0);
                  cnt       <= is_mult ? CW'(MULT_CYC) : CW'(DIV_CYC);
                  busy      <= 1'b1;
                  state     <= S_BUSY;
               end else if (req_en && hilo_type == HILO_MTHI) begin
                  hi <= src_a;
               end else if (req_en && hilo_type == HILO_MTLO) begin
                  lo <= src_a;
               end
            end
            S_BUSY: begin
               if (cnt == CW'(1)) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                  if (shadow_wr) begin
                     hi <= shadow_hi;
                     lo <= shadow_lo;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MDU_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= 32'd0;
      end else if (stall_md) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

   logic unused_none;
   assign unused_none = (hilo_type == HILO_NONE);

endmodule

// File: tb/tb_md_hilo_sched.sv
// tb/tb_md_hilo_sched.sv - self-checking bench for md_hilo_sched
// Directed cases plus randomized ops checked against an arithmetic reference model.
module tb_md_hilo_sched;

   localparam logic [3:0] T_NONE = 4'd0, T_MULT = 4'd1, T_MULTU = 4'd2, T_DIV = 4'd3,
                          T_DIVU = 4'd4, T_MFLO = 4'd5, T_MFHI = 4'd6, T_MTLO = 4'd7,
                          T_MTHI = 4'd8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_en;
   logic [3:0]  hilo_type;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        d_md_use;
   logic        start;
   logic        busy;
   logic        stall_md;
   logic [31:0] hilo_out;
   logic [31:0] hi;
   logic [31:0] lo;
`ifdef MDU_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   md_hilo_sched dut (
      .clk       (clk),
      .reset     (reset),
      .req_en    (req_en),
      .hilo_type (hilo_type),
      .src_a     (src_a),
      .src_b     (src_b),
      .d_md_use  (d_md_use),
      .start     (start),
      .busy      (busy),
      .stall_md  (stall_md),
      .hilo_out  (hilo_out),
      .hi        (hi),
      .lo        (lo)
`ifdef MDU_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: architectural HI/LO, cycles of busy left, pending result.
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          p_wr;
   int          m_left;
   logic [31:0] m_cnt;
   logic        last_stall;
   logic [31:0] last_hilo;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_wr = 0; m_left = 0; m_cnt = 0;
   endtask

   function automatic bit is_md(input logic [3:0] t);
      return (t == T_MULT) || (t == T_MULTU) || (t == T_DIV) || (t == T_DIVU);
   endfunction

   task automatic model_op(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl, output bit wr);
      longint sa, sb, q, r;
      logic [63:0] p;
      bit sgn;
      sgn = (t == T_MULT) || (t == T_DIV);
      sa  = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb  = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      rh = 0; rl = 0; wr = 1;
      if (t == T_MULT || t == T_MULTU) begin
         p  = sa * sb;
         rh = p[63:32];
         rl = p[31:0];
      end else if (b == 0) begin
         wr = 0;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         rl = q[31:0];
         rh = r[31:0];
      end
   endtask

   task automatic step(input logic en, input logic [3:0] t, input logic [31:0] a,
                       input logic [31:0] b, input logic dmd);
      logic        e_start, e_stall;
      logic [31:0] e_hilo;
      req_en = en; hilo_type = t; src_a = a; src_b = b; d_md_use = dmd;
      #1;
      e_start = en && is_md(t) && (m_left == 0);
      e_stall = dmd && (e_start || (m_left > 0));
      e_hilo  = (t == T_MFHI) ? m_hi : (t == T_MFLO) ? m_lo : 32'd0;
      check("start",    {63'd0, start},    {63'd0, e_start});
      check("busy",     {63'd0, busy},     {63'd0, (m_left > 0)});
      check("stall_md", {63'd0, stall_md}, {63'd0, e_stall});
      check("hilo_out", {32'd0, hilo_out}, {32'd0, e_hilo});
      check("hi",       {32'd0, hi},       {32'd0, m_hi});
      check("lo",       {32'd0, lo},       {32'd0, m_lo});
`ifdef MDU_PERF_CNT_EN
      check("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
`endif
      last_stall = stall_md;
      last_hilo  = hilo_out;
      @(posedge clk);
      if (e_stall) m_cnt = m_cnt + 1;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && p_wr) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (e_start) begin
         model_op(t, a, b, p_hi, p_lo, p_wr);
         m_left = (t == T_MULT || t == T_MULTU) ? 5 : 10;
      end else if (en && t == T_MTHI) begin
         m_hi = a;
      end else if (en && t == T_MTLO) begin
         m_lo = a;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, T_NONE, 32'd0, 32'd0, 1'b0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($signed($urandom_range(0, 40)) - 20);
         default: return $urandom;
      endcase
   endfunction

   int stalls;

   initial begin
      model_reset();
      reset = 1'b0; req_en = 0; hilo_type = T_NONE; src_a = 0; src_b = 0; d_md_use = 0;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      idle(1);

      // 1: mult -2 * 3
      step(1'b1, T_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
      idle(5);
      check("t1_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
      check("t1_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFA});

      // 2: multu then mfhi right after busy falls
      step(1'b1, T_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      idle(5);
      step(1'b1, T_MFHI, 32'd0, 32'd0, 1'b0);
      check("t2_mfhi", {32'd0, last_hilo}, {32'd0, 32'd1});
      check("t2_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFE});

      // 3: div -7/2, then divu by zero leaves HI/LO
      step(1'b1, T_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(10);
      check("t3_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});
      check("t3_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});
      step(1'b1, T_DIVU, 32'd7, 32'd0, 1'b0);
      idle(10);
      check("t3_div0_lo", {32'd0, lo}, {32'd0, 32'hFFFF_FFFD});
      check("t3_div0_hi", {32'd0, hi}, {32'd0, 32'hFFFF_FFFF});

      // div overflow corner
      step(1'b1, T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(10);
      check("ovf_lo", {32'd0, lo}, {32'd0, 32'h8000_0000});
      check("ovf_hi", {32'd0, hi}, {32'd0, 32'd0});

      // 4: stall window of a mult
      stalls = 0;
      step(1'b1, T_MULT, 32'd3, 32'd4, 1'b1);
      stalls += int'(last_stall);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, T_NONE, 32'd0, 32'd0, 1'b1);
         stalls += int'(last_stall);
      end
      step(1'b0, T_NONE, 32'd0, 32'd0, 1'b1);
      check("t4_after", {63'd0, last_stall}, 64'd0);
      check("t4_stalls", 64'(stalls), 64'd6);

      // 5: mthi gated by req_en
      step(1'b0, T_MTHI, 32'h1234, 32'd0, 1'b0);
      idle(1);
      check("t5_gated", {32'd0, hi}, {32'd0, 32'd0});
      step(1'b1, T_MTHI, 32'h1234, 32'd0, 1'b0);
      idle(1);
      check("t5_hi", {32'd0, hi}, {32'd0, 32'h1234});
      check("t5_busy", {63'd0, busy}, 64'd0);

      // random traffic obeying the stall
      for (int i = 0; i < 400; i++) begin
         logic [3:0] t;
         if (m_left > 0) begin
            case ($urandom_range(0, 2))
               0:       t = T_NONE;
               1:       t = T_MFLO;
               default: t = T_MFHI;
            endcase
         end else begin
            t = 4'($urandom_range(0, 8));
         end
         step(1'($urandom_range(0, 4) != 0), t, pick(), pick(), 1'($urandom_range(0, 1)));
      end
      idle(11);

      // 6: async reset during the 3rd busy cycle of a div
      step(1'b1, T_MTLO, 32'h5555_AAAA, 32'd0, 1'b0);
      step(1'b1, T_DIV, 32'd100, 32'd7, 1'b0);
      idle(2);
      reset = 1'b0;
      #1;
      check("t6_busy", {63'd0, busy}, 64'd0);
      check("t6_hi", {32'd0, hi}, 64'd0);
      check("t6_lo", {32'd0, lo}, 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      step(1'b1, T_MFLO, 32'd0, 32'd0, 1'b0);
      check("t6_mflo", {32'd0, last_hilo}, 64'd0);
      idle(12);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
